// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-port word RAM with
// asynchronous read. Handles byte/half/word accesses, little-endian lane
// extraction with sign/zero extension, read-modify-write for sub-word stores,
// and rejects misaligned, reserved-size or out-of-range requests.
module load_store_unit #(
   parameter int unsigned ADDRESS_SIZE = 1024,
   localparam int unsigned AW = (ADDRESS_SIZE > 1) ? $clog2(ADDRESS_SIZE) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   // CPU request
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [31:0]   req_addr,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [31:0]   req_wdata,
   // CPU response
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_error,
   // RAM port
   output logic [AW-1:0] mem_address,
   output logic          mem_write,
   output logic [31:0]   mem_write_data,
   input  logic [31:0]   mem_read_data
);

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRd   = 2'b01,
      StWr   = 2'b10,
      StResp = 2'b11
   } state_e;

   state_e state_q, state_d;

   // Request fields latched at accept
   logic          write_q;
   logic          unsigned_q;
   logic [1:0]    size_q;
   logic [1:0]    lane_q;
   logic [31:0]   wdata_q;
   logic [AW-1:0] waddr_q;

   // Word captured in RD, and the registered response
   logic [31:0]   rword_q;
   logic [31:0]   rsp_rdata_q;
   logic          rsp_error_q;

   logic          accept;
   logic          req_err;
   logic [7:0]    load_byte;
   logic [15:0]   load_half;
   logic [31:0]   load_data;
   logic [31:0]   merged_word;

   // Classify the incoming request: reserved size, misalignment or out-of-range word
   always_comb begin
      req_err = 1'b0;
      unique case (req_size)
         SizeByte: req_err = 1'b0;
         SizeHalf: req_err = req_addr[0];
         SizeWord: req_err = |req_addr[1:0];
         default:  req_err = 1'b1;
      endcase
      if ({2'b00, req_addr[31:2]} >= ADDRESS_SIZE) begin
         req_err = 1'b1;
      end
   end

   // Extract the addressed lane(s) from the RAM word and extend to 32 bits
   always_comb begin
      load_byte = 8'h00;
      unique case (lane_q)
         2'd0:    load_byte = mem_read_data[7:0];
         2'd1:    load_byte = mem_read_data[15:8];
         2'd2:    load_byte = mem_read_data[23:16];
         default: load_byte = mem_read_data[31:24];
      endcase
      load_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

      load_data = mem_read_data;
      unique case (size_q)
         SizeByte: load_data = {{24{~unsigned_q & load_byte[7]}}, load_byte};
         SizeHalf: load_data = {{16{~unsigned_q & load_half[15]}}, load_half};
         default:  load_data = mem_read_data;
      endcase
   end

   // Merge store data into the word read in RD; word stores bypass the merge
   always_comb begin
      merged_word = rword_q;
      unique case (size_q)
         SizeByte: merged_word[{lane_q, 3'b000} +: 8]        = wdata_q[7:0];
         SizeHalf: merged_word[{lane_q[1], 4'b0000} +: 16]   = wdata_q[15:0];
         default:  merged_word = wdata_q;
      endcase
   end

   // Next-state logic and control outputs
   always_comb begin
      state_d   = state_q;
      req_ready = rst_n && (state_q == StIdle);
      accept    = req_valid && req_ready;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_err) begin
                  state_d = StResp;
               end else if (!req_write) begin
                  state_d = StRd;
               end else if (req_size == SizeWord) begin
                  state_d = StWr;
               end else begin
                  // Sub-word store needs the current word first
                  state_d = StRd;
               end
            end
         end
         StRd:    state_d = write_q ? StWr : StResp;
         StWr:    state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      rsp_valid      = (state_q == StResp);
      rsp_rdata      = rsp_rdata_q;
      rsp_error      = rsp_error_q;
      mem_address    = waddr_q;
      // Gated by reset so asserting reset during WR never writes the RAM
      mem_write      = rst_n && (state_q == StWr);
      mem_write_data = (state_q == StWr) ? merged_word : 32'h0000_0000;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch request fields on accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= 2'b00;
         lane_q     <= 2'b00;
         wdata_q    <= 32'h0000_0000;
         waddr_q    <= '0;
      end else if (accept) begin
         write_q    <= req_write;
         unsigned_q <= req_unsigned;
         size_q     <= req_size;
         lane_q     <= req_addr[1:0];
         wdata_q    <= req_wdata;
         waddr_q    <= req_addr[AW+1:2];
      end
   end

   // Capture the RAM word in RD and update the held response on entry to RESP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rword_q     <= 32'h0000_0000;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_error_q <= 1'b0;
      end else begin
         if (state_q == StRd) begin
            rword_q <= mem_read_data;
         end
         if (accept && req_err) begin
            rsp_rdata_q <= 32'h0000_0000;
            rsp_error_q <= 1'b1;
         end else if ((state_q == StRd) && !write_q) begin
            rsp_rdata_q <= load_data;
            rsp_error_q <= 1'b0;
         end else if (state_q == StWr) begin
            rsp_rdata_q <= 32'h0000_0000;
            rsp_error_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests checked
// against a word-array reference model of memory and response timing.
module tb_load_store_unit;

   localparam int unsigned ADDRESS_SIZE = 1024;
   localparam int unsigned AW = $clog2(ADDRESS_SIZE);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [31:0]   req_addr;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_error;
   logic [AW-1:0] mem_address;
   logic          mem_write;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;

   // RAM (async read, write on rising edge) plus a preload port for the bench
   logic [31:0]   ram [ADDRESS_SIZE];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [31:0]   pre_data = '0;

   // Reference memory image kept by the bench
   logic [31:0]   ref_mem [ADDRESS_SIZE];

   int n_tests = 0;
   int n_fail  = 0;

   int          last_lat;
   logic [31:0] last_rd;
   logic        last_err;
   logic [31:0] last_wdat;
   int          last_pulses;

   load_store_unit #(.ADDRESS_SIZE(ADDRESS_SIZE)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_error      (rsp_error),
      .mem_address    (mem_address),
      .mem_write      (mem_write),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   assign mem_read_data = ram[mem_address];

   always @(posedge clk) begin
      if (mem_write) ram[mem_address] <= mem_write_data;
      else if (pre_we) ram[pre_addr] <= pre_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int unsigned wa, input logic [31:0] data);
      pre_we   = 1'b1;
      pre_addr = AW'(wa);
      pre_data = data;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
      ref_mem[wa] = data;
   endtask

   // Reference model: error rules, latency, load value and store result by arithmetic
   task automatic model(input bit w, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wd, output int lat,
                        output bit err, output logic [31:0] rd, output logic [31:0] wdx);
      longint m, v, o;
      int unsigned wa, sh, nb;
      err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
            || ((addr >> 2) >= ADDRESS_SIZE);
      rd  = 32'h0;
      wdx = 32'h0;
      lat = 1;
      if (!err) begin
         wa = addr >> 2;
         sh = 8 * (addr % 4);
         nb = 1 << size;
         m  = (longint'(1) << (8 * nb)) - 1;
         o  = longint'(ref_mem[wa]);
         if (!w) begin
            v = (o >> sh) & m;
            if (!uns && v >= (m + 1) / 2) v = v - (m + 1);
            rd  = 32'(v);
            lat = 2;
         end else begin
            v   = (o & ~(m << sh)) | ((longint'(wd) & m) << sh);
            wdx = 32'(v);
            ref_mem[wa] = wdx;
            lat = (size == 2'd2) ? 2 : 3;
         end
      end
   endtask

   task automatic do_req(input bit w, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wd, input string tag);
      int          e_lat, lat, pulses;
      bit          e_err;
      logic [31:0] e_rd, e_wd, e_wa, g_wd, g_wa;
      e_wa = 32'((addr >> 2) % ADDRESS_SIZE);
      model(w, addr, size, uns, wd, e_lat, e_err, e_rd, e_wd);
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_write    = w;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wd;
      @(posedge clk);
      #1;
      // Scramble the inputs so only latched values can produce the right result
      req_valid    = 1'b0;
      req_write    = 1'($urandom);
      req_addr     = $urandom;
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = $urandom;
      lat = 0; pulses = 0; g_wd = 32'h0; g_wa = 32'h0;
      last_rd = 'x; last_err = 1'bx;
      for (int c = 1; c <= 8; c++) begin
         if (mem_write) begin
            pulses++;
            g_wd = mem_write_data;
            g_wa = 32'(mem_address);
         end
         if (rsp_valid) begin
            lat      = c;
            last_rd  = rsp_rdata;
            last_err = rsp_error;
            break;
         end
         check({tag, " mem_address"}, 32'(mem_address), e_wa);
         @(posedge clk);
         #1;
      end
      check({tag, " latency"}, 32'(lat), 32'(e_lat));
      check({tag, " rsp_error"}, 32'(last_err), 32'(e_err));
      check({tag, " rsp_rdata"}, last_rd, e_rd);
      check({tag, " write pulses"}, 32'(pulses), 32'(w && !e_err));
      if (w && !e_err) begin
         check({tag, " write data"}, g_wd, e_wd);
         check({tag, " write addr"}, g_wa, e_wa);
      end
      @(posedge clk);
      #1;
      check({tag, " rsp one cycle"}, 32'(rsp_valid), 32'd0);
      check({tag, " rdata held"}, rsp_rdata, e_rd);
      if (w && !e_err) check({tag, " ram"}, ram[e_wa], ref_mem[e_wa]);
      last_lat    = lat;
      last_wdat   = g_wd;
      last_pulses = pulses;
   endtask

   initial begin
      logic [31:0] q_addr [3];
      logic [31:0] q_wd   [3];
      logic [1:0]  q_sz   [3];
      bit          q_w    [3];
      int          q_lat  [3];
      bit          q_err  [3];
      logic [31:0] q_rd   [3];
      logic [31:0] dummy;
      int          acc_c  [3];
      int          rsp_c  [3];
      int          idx, nr;
      bit          acc, seen;

      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = 32'h0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_wdata    = 32'h0;

      // Outputs while reset is held
      #2;
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset mem_write", 32'(mem_write), 32'd0);
      for (int i = 0; i < int'(ADDRESS_SIZE); i++) poke(i, $urandom);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset rsp_error", 32'(rsp_error), 32'd0);
      check("reset mem_address", 32'(mem_address), 32'd0);
      check("reset mem_write_data", mem_write_data, 32'd0);
      rst_n = 1'b1;
      #1;
      check("release req_ready", 32'(req_ready), 32'd1);

      // Word store then word load
      do_req(1'b1, 32'h000, 2'd2, 1'b0, 32'h0000_018C, "w_store");
      check("w_store pulse", 32'(last_pulses), 32'd1);
      do_req(1'b0, 32'h000, 2'd2, 1'b0, 32'h0, "w_load");
      check("w_load value", last_rd, 32'h0000_018C);
      check("w_load latency", 32'(last_lat), 32'd2);

      // Byte store read-modify-write
      poke(32'h16A, 32'h1122_3344);
      do_req(1'b1, 32'h5A9, 2'd0, 1'b0, 32'h0000_00AB, "b_store");
      check("b_store merged", last_wdat, 32'h1122_AB44);
      check("b_store latency", 32'(last_lat), 32'd3);

      // Half loads, signed and unsigned
      poke(32'h04B, 32'h8001_FFFF);
      do_req(1'b0, 32'h12E, 2'd1, 1'b0, 32'h0, "h_load_s");
      check("h_load_s value", last_rd, 32'hFFFF_8001);
      do_req(1'b0, 32'h12E, 2'd1, 1'b1, 32'h0, "h_load_u");
      check("h_load_u value", last_rd, 32'h0000_8001);

      // Error cases
      do_req(1'b1, 32'h12E, 2'd2, 1'b0, 32'h1234_5678, "err_w_misalign");
      check("err_w_misalign flag", 32'(last_err), 32'd1);
      do_req(1'b0, 32'h001, 2'd1, 1'b0, 32'h0, "err_h_misalign");
      check("err_h_misalign flag", 32'(last_err), 32'd1);
      do_req(1'b1, 32'h000, 2'd3, 1'b0, 32'h5555_5555, "err_size");
      check("err_size flag", 32'(last_err), 32'd1);
      do_req(1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0, "err_range");
      check("err_range flag", 32'(last_err), 32'd1);
      check("err_range latency", 32'(last_lat), 32'd1);

      // Reset during the WR cycle of a word store
      poke(32'h010, 32'h0102_0304);
      check("rst_wr ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_size = 2'd2;
      req_unsigned = 1'b0; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rst_wr in WR", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_wr write gated", 32'(mem_write), 32'd0);
      check("rst_wr ready low", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rst_wr rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_wr rsp_rdata", rsp_rdata, 32'd0);
      check("rst_wr mem_address", 32'(mem_address), 32'd0);
      check("rst_wr mem_write_data", mem_write_data, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_wr ready after", 32'(req_ready), 32'd1);
      seen = 1'b0;
      repeat (4) begin
         if (rsp_valid || mem_write) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      check("rst_wr no activity", 32'(seen), 32'd0);
      check("rst_wr ram kept", ram[32'h010], 32'h0102_0304);
      do_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, "rst_wr reload");

      // Three requests with req_valid held high
      q_w[0] = 1'b1; q_addr[0] = 32'h41; q_sz[0] = 2'd0; q_wd[0] = 32'h0000_0077;
      q_w[1] = 1'b0; q_addr[1] = 32'h40; q_sz[1] = 2'd2; q_wd[1] = 32'h0;
      q_w[2] = 1'b0; q_addr[2] = 32'h03; q_sz[2] = 2'd1; q_wd[2] = 32'h0;
      for (int i = 0; i < 3; i++) begin
         model(q_w[i], q_addr[i], q_sz[i], 1'b0, q_wd[i], q_lat[i], q_err[i], q_rd[i], dummy);
         acc_c[i] = -100;
         rsp_c[i] = -100;
      end
      idx = 0; nr = 0;
      req_valid = 1'b1; req_write = q_w[0]; req_addr = q_addr[0]; req_size = q_sz[0];
      req_unsigned = 1'b0; req_wdata = q_wd[0];
      for (int cyc = 0; cyc < 40 && nr < 3; cyc++) begin
         if (rsp_valid) begin
            check("b2b rdata", rsp_rdata, q_rd[nr]);
            check("b2b error", 32'(rsp_error), 32'(q_err[nr]));
            check("b2b latency", 32'(cyc - acc_c[nr]), 32'(q_lat[nr]));
            rsp_c[nr] = cyc;
            nr++;
         end
         acc = req_valid && req_ready;
         if (acc) begin
            acc_c[idx] = cyc;
            if (idx > 0) check("b2b accept cycle", 32'(cyc), 32'(rsp_c[idx-1] + 1));
         end
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < 3) begin
               req_write = q_w[idx]; req_addr = q_addr[idx];
               req_size = q_sz[idx]; req_wdata = q_wd[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      check("b2b responses", 32'(nr), 32'd3);
      check("b2b ram", ram[32'h010], ref_mem[32'h010]);
      @(posedge clk);
      #1;

      // Randomized requests against the reference model
      for (int i = 0; i < 150; i++) begin
         int unsigned r, s;
         logic [31:0] a;
         logic [1:0]  sz;
         r = $urandom % 16;
         s = $urandom % 8;
         sz = (s == 7) ? 2'd3 : 2'(s % 3);
         a = (r == 0) ? $urandom : 32'($urandom_range(0, 4095));
         if (r > 2) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         do_req(1'($urandom), a, sz, 1'($urandom), $urandom, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDRESS_SIZE, default 1024, is the RAM depth in 32-bit words; AW = $clog2(ADDRESS_SIZE).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST_N  in  1  reset, synchronous, active-low.
REQ-004 REQ_VALID  in  1  CPU request present.
REQ-005 REQ_READY  out  1  unit can accept a request.
REQ-006 REQ_WRITE  in  1  1 = store, 0 = load.
REQ-007 REQ_ADDR  in  32  byte address.
REQ-008 REQ_SIZE  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 REQ_UNSIGNED  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 REQ_WDATA  in  32  store data, right-aligned.
REQ-011 RSP_VALID  out  1  one-cycle completion pulse.
REQ-012 RSP_RDATA  out  32  extended load data.
REQ-013 RSP_ERROR  out  1  request rejected; valid with RSP_VALID.
REQ-014 MEM_ADDRESS  out  AW  RAM word address.
REQ-015 MEM_WRITE  out  1  RAM write enable; the RAM writes on the rising edge.
REQ-016 MEM_WRITE_DATA  out  32  RAM write data.
REQ-017 MEM_READ_DATA  in  32  RAM asynchronous read data for MEM_ADDRESS.

Function
REQ-018 The unit SHALL implement FSM states IDLE, RD, WR and RESP.
- REQ_READY = 1 only in IDLE with RST_N = 1.
REQ-019 A request is accepted at an edge where REQ_VALID = 1 and REQ_READY = 1.
- At accept, the unit latches write, size, unsigned, wdata, byte lane REQ_ADDR[1:0] and word address REQ_ADDR[AW+1:2].
REQ-020 An accepted request is an error when any of the following holds:
- size = 11;
- half with addr[0] = 1;
- word with addr[1:0] != 00;
- REQ_ADDR[31:2] >= ADDRESS_SIZE.
REQ-021 On error, the next state is RESP with RSP_ERROR = 1 and RSP_RDATA = 0.
- No RAM write occurs.
- Latency: RSP_VALID is high in the 1st cycle after accept.
REQ-022 Valid load: IDLE -> RD -> RESP.
- In RD, MEM_ADDRESS = latched word address and MEM_WRITE = 0.
- MEM_READ_DATA is captured at the RD-exit edge.
- RSP_VALID is high in the 2nd cycle after accept.
REQ-023 Load extraction is little-endian: lane n = bits [8n+7:8n], and a half uses lanes {addr[1],0}.
- Extension to 32 bits follows REQ_UNSIGNED.
REQ-024 Valid word store: IDLE -> WR -> RESP.
- In WR, MEM_WRITE = 1 and MEM_WRITE_DATA = wdata.
- RSP_VALID is high in the 2nd cycle after accept.
REQ-025 Valid byte or half store performs a read-modify-write: IDLE -> RD -> WR -> RESP.
- In WR, MEM_WRITE_DATA = word captured in RD with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- RSP_VALID is high in the 3rd cycle after accept.
REQ-026 MEM_WRITE SHALL be 1 only in WR, for exactly one cycle per store, and SHALL be gated by RST_N.
REQ-027 MEM_WRITE_DATA SHALL be 0 outside WR; MEM_ADDRESS SHALL hold the last latched word address.
REQ-028 RESP lasts exactly one cycle and then returns to IDLE.
- RSP_VALID = 1 only in RESP.
- For stores, RSP_RDATA = 0.
- RSP_RDATA and RSP_ERROR hold their values until the next RESP.
REQ-029 Back-to-back operation: the next request can be accepted in the cycle following RESP.
- REQ_VALID is ignored outside IDLE.

Reset
REQ-030 When RST_N = 0 at an edge, the FSM SHALL go to IDLE and all latched fields and the captured read word SHALL be cleared to 0.
REQ-031 Output values while RST_N = 0 and after the reset edge:
- REQ_READY = 0 and MEM_WRITE = 0 combinationally while RST_N = 0.
- After the reset edge: RSP_VALID = 0, RSP_RDATA = 0, RSP_ERROR = 0, MEM_ADDRESS = 0, MEM_WRITE_DATA = 0.
REQ-032 Reset asserted in any state aborts the operation with no response pulse.
- Reset asserted in WR SHALL NOT write the RAM.
- REQ_READY = 1 in the first cycle with RST_N = 1.

Verification
REQ-033 Word store 0x0000018C at addr 0x000, then word load at 0x000 -> one MEM_WRITE pulse with MEM_ADDRESS 0x000; load RSP_RDATA = 0x0000018C, RSP_ERROR = 0, with latency 2.
REQ-034 Word 0x16A preloaded with 0x11223344; byte store 0xAB at addr 0x5A9 -> RD then WR, MEM_WRITE_DATA = 0x1122AB44, RSP_VALID at cycle 3.
REQ-035 Word 0x04B = 0x8001FFFF; half load at 0x12E, signed -> 0xFFFF8001; unsigned -> 0x00008001.
REQ-036 Error handling -> RSP_VALID with RSP_ERROR = 1 at cycle 1 and MEM_WRITE never 1, for each case:
- word store at 0x12E;
- half load at 0x001;
- size 11;
- word access at 0x00001000 (word 0x400 with ADDRESS_SIZE = 1024).
REQ-037 RST_N = 0 during the WR cycle of a store of 0xDEADBEEF to word 0x010 -> no RAM write, word 0x010 keeps its old value, no RSP_VALID, REQ_READY = 1 after release.
REQ-038 Three consecutive requests held on REQ_VALID -> each accepted only in IDLE, one RSP_VALID pulse per request, in order.
